// File: rtl/midi_pkg.sv
// midi_pkg: MIDI status/CC constants and the decoded-event type shared by the voice allocator
package midi_pkg;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON = 4'h9;
  localparam logic [3:0] MIDI_CC = 4'hB;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  typedef enum logic [1:0] {EV_NONE, EV_ON, EV_OFF, EV_ALL_OFF} ev_t;
endpackage

// File: rtl/voice_age_tracker.sv
// voice_age_tracker: per-slot age permutation (0 = newest); in clk_in/rst_n_in/alloc/alloc_idx, out oldest slot index
module voice_age_tracker #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W = $clog2(NUM_VOICES)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             alloc,
  input  logic [AGE_W-1:0] alloc_idx,
  output logic [AGE_W-1:0] oldest
);
  logic [AGE_W-1:0] age [NUM_VOICES];
  always_ff @(posedge clk_in)
    for (int i = 0; i < NUM_VOICES; i++)
      if (!rst_n_in) age[i] <= AGE_W'(i);
      else if (alloc) age[i] <= (i == int'(alloc_idx)) ? '0 : (age[i] < age[alloc_idx]) ? age[i] + 1'b1 : age[i];
  always_comb begin
    oldest = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (age[i] == AGE_W'(NUM_VOICES - 1)) oldest = AGE_W'(i);
  end
endmodule

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: MIDI note events -> polyphonic slots with oldest-steal; in status/data/valid, out per-slot note/velocity/gate/trig + active count
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W = $clog2(NUM_VOICES)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [3:0]              status_in,
  input  logic [7:0]              data_byte1_in,
  input  logic [7:0]              data_byte2_in,
  input  logic                    valid_in,
  output logic [NUM_VOICES*7-1:0] note_out,
  output logic [NUM_VOICES*7-1:0] velocity_out,
  output logic [NUM_VOICES-1:0]   gate_out,
  output logic [NUM_VOICES-1:0]   trig_out,
  output logic [AGE_W:0]          active_count_out
);
  logic [6:0] d1, d2;
  ev_t ev;
  logic hit, free;
  logic [AGE_W-1:0] hit_idx, free_idx, oldest, tgt;
  logic [NUM_VOICES-1:0] gate_nxt;
  logic [AGE_W:0] cnt_nxt;
  assign d1 = data_byte1_in[6:0];
  assign d2 = data_byte2_in[6:0];
  always_comb
    ev = !valid_in ? EV_NONE :
         (status_in == MIDI_NOTE_ON && d2 != '0) ? EV_ON :
         (status_in == MIDI_NOTE_OFF || status_in == MIDI_NOTE_ON) ? EV_OFF :
         (status_in == MIDI_CC && d1 == CC_ALL_NOTES_OFF) ? EV_ALL_OFF : EV_NONE;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_out[i] && note_out[i*7 +: 7] == d1) begin
        hit = 1'b1;
        hit_idx = AGE_W'(i);
      end
      if (!gate_out[i]) begin
        free = 1'b1;
        free_idx = AGE_W'(i);
      end
    end
  end
  assign tgt = hit ? hit_idx : free ? free_idx : oldest;
  always_comb begin
    gate_nxt = gate_out;
    if (ev == EV_ON) gate_nxt[tgt] = 1'b1;
    else if (ev == EV_OFF && hit) gate_nxt[hit_idx] = 1'b0;
    else if (ev == EV_ALL_OFF) gate_nxt = '0;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_VOICES; i++) cnt_nxt = cnt_nxt + (AGE_W+1)'(gate_nxt[i]);
  end
  voice_age_tracker #(.NUM_VOICES(NUM_VOICES), .AGE_W(AGE_W)) u_age (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .alloc(ev == EV_ON),
    .alloc_idx(tgt),
    .oldest(oldest)
  );
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      note_out <= '0;
      velocity_out <= '0;
      gate_out <= '0;
      trig_out <= '0;
      active_count_out <= '0;
    end else begin
      trig_out <= '0;
      gate_out <= gate_nxt;
      active_count_out <= cnt_nxt;
      if (ev == EV_ON) begin
        note_out[tgt*7 +: 7] <= d1;
        velocity_out[tgt*7 +: 7] <= d2;
        trig_out[tgt] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: directed vectors with a scoreboard queue checked one cycle after each stimulus edge
module tb_midi_voice_allocator;
  localparam int NV = 4;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [3:0] status_in = '0;
  logic [7:0] data_byte1_in = '0, data_byte2_in = '0;
  logic valid_in = 1'b0;
  logic [NV*7-1:0] note_out, velocity_out;
  logic [NV-1:0] gate_out, trig_out;
  logic [2:0] active_count_out;
  typedef struct {
    int id;
    logic [NV*7-1:0] note;
    logic [NV*7-1:0] vel;
    logic [NV-1:0] gate;
    logic [NV-1:0] trig;
    logic [2:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [NV*7-1:0] sh_note = '0, sh_vel = '0;
  int n_id = 0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk_in = ~clk_in;
  midi_voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .status_in(status_in),
    .data_byte1_in(data_byte1_in),
    .data_byte2_in(data_byte2_in),
    .valid_in(valid_in),
    .note_out(note_out),
    .velocity_out(velocity_out),
    .gate_out(gate_out),
    .trig_out(trig_out),
    .active_count_out(active_count_out)
  );
  always @(posedge clk_in) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (note_out !== e.note || velocity_out !== e.vel || gate_out !== e.gate || trig_out !== e.trig || active_count_out !== e.cnt) begin
        miscompares++;
        $display("FAIL vec%0d: note got %h exp %h, vel got %h exp %h, gate got %b exp %b, trig got %b exp %b, count got %0d exp %0d",
                 e.id, note_out, e.note, velocity_out, e.vel, gate_out, e.gate, trig_out, e.trig, active_count_out, e.cnt);
      end
    end
  end
  task automatic push(input logic [NV-1:0] g, input logic [NV-1:0] t);
    exp_t x;
    x.id = n_id++;
    x.note = sh_note;
    x.vel = sh_vel;
    x.gate = g;
    x.trig = t;
    x.cnt = 3'($countones(g));
    q.push_back(x);
  endtask
  task automatic msg(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2, input int slot, input logic [NV-1:0] g, input logic [NV-1:0] t);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    valid_in = 1'b1;
    status_in = st;
    data_byte1_in = b1;
    data_byte2_in = b2;
    if (slot >= 0) begin
      sh_note[slot*7 +: 7] = b1[6:0];
      sh_vel[slot*7 +: 7] = b2[6:0];
    end
    push(g, t);
  endtask
  task automatic idle(input logic [NV-1:0] g);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    valid_in = 1'b0;
    push(g, '0);
  endtask
  task automatic do_reset(input logic v, input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    valid_in = v;
    status_in = st;
    data_byte1_in = b1;
    data_byte2_in = b2;
    sh_note = '0;
    sh_vel = '0;
    push('0, '0);
  endtask
  task automatic fill4;
    msg(4'h9, 8'd60, 8'd80, 0, 4'b0001, 4'b0001);
    msg(4'h9, 8'd62, 8'd80, 1, 4'b0011, 4'b0010);
    msg(4'h9, 8'd64, 8'd80, 2, 4'b0111, 4'b0100);
    msg(4'h9, 8'd65, 8'd80, 3, 4'b1111, 4'b1000);
  endtask
  initial begin
    do_reset(1'b0, 4'h0, 8'd0, 8'd0);
    msg(4'h9, 8'd60, 8'd100, 0, 4'b0001, 4'b0001);
    msg(4'h9, 8'd64, 8'd90, 1, 4'b0011, 4'b0010);
    idle(4'b0011);
    do_reset(1'b0, 4'h0, 8'd0, 8'd0);
    fill4();
    msg(4'h9, 8'd67, 8'd70, 0, 4'b1111, 4'b0001);
    msg(4'h9, 8'd69, 8'd50, 1, 4'b1111, 4'b0010);
    idle(4'b1111);
    msg(4'h9, 8'd71, 8'd40, 2, 4'b1111, 4'b0100);
    do_reset(1'b0, 4'h0, 8'd0, 8'd0);
    msg(4'h9, 8'hBC, 8'hE4, 0, 4'b0001, 4'b0001);
    msg(4'h9, 8'd60, 8'd127, 0, 4'b0001, 4'b0001);
    msg(4'h9, 8'd60, 8'd0, -1, 4'b0000, 4'b0000);
    msg(4'h9, 8'd72, 8'd33, 0, 4'b0001, 4'b0001);
    msg(4'h8, 8'd72, 8'd64, -1, 4'b0000, 4'b0000);
    msg(4'h8, 8'd72, 8'd64, -1, 4'b0000, 4'b0000);
    do_reset(1'b0, 4'h0, 8'd0, 8'd0);
    fill4();
    msg(4'hB, 8'd7, 8'd100, -1, 4'b1111, 4'b0000);
    msg(4'h8, 8'd50, 8'd0, -1, 4'b1111, 4'b0000);
    msg(4'hA, 8'd60, 8'd10, -1, 4'b1111, 4'b0000);
    msg(4'h8, 8'd62, 8'd0, -1, 4'b1101, 4'b0000);
    msg(4'h9, 8'd70, 8'd10, 1, 4'b1111, 4'b0010);
    msg(4'hB, 8'd123, 8'd0, -1, 4'b0000, 4'b0000);
    idle(4'b0000);
    do_reset(1'b0, 4'h0, 8'd0, 8'd0);
    msg(4'h9, 8'd60, 8'd80, 0, 4'b0001, 4'b0001);
    msg(4'h9, 8'd62, 8'd80, 1, 4'b0011, 4'b0010);
    msg(4'h9, 8'd64, 8'd80, 2, 4'b0111, 4'b0100);
    do_reset(1'b1, 4'h9, 8'd67, 8'd80);
    msg(4'h9, 8'd72, 8'd5, 0, 4'b0001, 4'b0001);
    @(negedge clk_in);
    valid_in = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk_in);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Downstream consumer of the MIDI byte parser's event stream (status nibble, two data bytes, one-cycle valid).
- Decodes Note On, Note Off and All Notes Off into a fixed pool of polyphonic voice slots.
- Per slot it drives note, velocity, gate and a one-cycle retrigger pulse to the oscillator/envelope bank.
- When every slot is gated, a new note steals the oldest allocated slot.

Parameters:
- NUM_VOICES, 4, number of voice slots; power of two, 2..16.
- AGE_W, $clog2(NUM_VOICES), width of each slot's age rank (derived; do not override).

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_n_in  input  1  reset, synchronous, active-low.
- status_in  input  4  MIDI status upper nibble from parser.
- data_byte1_in  input  8  note number or CC number; bit 7 ignored.
- data_byte2_in  input  8  velocity or CC value; bit 7 ignored.
- valid_in  input  1  one-cycle strobe: status/data are a complete message.
- note_out  output  NUM_VOICES x 7  note number held by each slot.
- velocity_out  output  NUM_VOICES x 7  velocity of each slot.
- gate_out  output  NUM_VOICES  slot sounding.
- trig_out  output  NUM_VOICES  one-cycle pulse when a slot is (re)started.
- active_count_out  output  AGE_W+1  number of gated slots.

Behaviour:
- Reset (rst_n_in low at a clock edge) overrides every other input.
  - Clears note_out, velocity_out, gate_out, trig_out and active_count_out to 0.
  - Sets the age of slot i to i.
- Ages always form a permutation of 0..NUM_VOICES-1. 0 means most recently allocated.
- All outputs are registered. A message with valid_in high at edge N is visible after edge N+1 (latency 1). Back-to-back valid cycles are accepted, one message per cycle.
- trig_out is high for exactly the one cycle after the allocating edge, otherwise 0.
- Decode applies only when valid_in=1; the two data bytes below are taken as [6:0].
  - Note On: status 4'h9 with velocity != 0.
    - Match: a gated slot already holds the note. Update that slot's velocity, pulse its trig, and make it age 0.
    - Free: no match and some slot is ungated. Take the lowest-index ungated slot, load note and velocity, set gate, pulse trig, make it age 0.
    - Steal: no match and all slots gated. Take the slot with age NUM_VOICES-1 and handle it as Free (gate stays 1, trig pulses).
    - Age update for slot v with old age a: every slot with age < a increments, v becomes 0, the rest are unchanged.
  - Note Off: status 4'h8, or status 4'h9 with velocity 0.
    - Clears gate of the gated slot holding that note; note_out and velocity_out hold for the envelope release.
    - Ages are unchanged. Note Off for a note not held, or held only by an ungated slot, is ignored.
  - All Notes Off: status 4'hB with data_byte1=123. Clears every gate; ages are unchanged.
  - Any other status, or other CC numbers, is ignored: no output changes and no trig.
- active_count_out equals the popcount of gate_out, registered in the same cycle.
- At most one slot ever gates a given note; enforced by the Match rule.
- valid_in while rst_n_in is low is discarded.

Decomposition:
- Shared package midi_pkg holds:
  - status constants MIDI_NOTE_OFF=4'h8, MIDI_NOTE_ON=4'h9, MIDI_CC=4'hB;
  - CC_ALL_NOTES_OFF=7'd123;
  - a decoded-event enum {EV_NONE, EV_ON, EV_OFF, EV_ALL_OFF}.
- Sub-module voice_age_tracker holds the age permutation registers. It takes an allocate strobe and slot index, and outputs the oldest-slot index. Reset and update rules are as above.
- Match search, free-slot priority encoding and gate/note registers remain in the top.

Test Plan:
- After reset, Note On 60/100 then 64/90: slot0=60/100 and slot1=64/90 gated, trig pulses on slot0 then slot1 one cycle each, active_count 2.
- Note On 60,62,64,65 (all vel 80), then Note On 67/70: slot0 stolen -> note 67, velocity 70, gate stays 1, trig[0] pulses, active_count stays 4.
  - Then Note On 69: steals slot1.
- Hold 60 in slot0 and send Note On 60/127: slot0 velocity becomes 127 and trig[0] pulses; no other slot is allocated.
- Note On 60/100 then Note On 60/0: gate[0]=0, note_out[0] stays 60; a following Note On 72 reuses slot0.
- Four notes held, then CC 123/0: gate_out=0, active_count 0.
  - Also: CC 7/100 and Note Off 50 (not held) produce no change.
- Assert rst_n_in low mid-stream with valid_in high on 3 held notes: all outputs 0 at the next cycle, message discarded, next Note On lands in slot0.
